// File: rtl/stack_control_fsm.sv
// Multi-cycle stack processor control FSM: FETCH/DECODE/EXEC with a memory-ready wait and stack occupancy checks.
// Optional macro STACK_TRAP_EN: faults enter a sticky TRAP state reporting trap_cause instead of becoming NOPs.
module stack_control_fsm #(
    parameter int INST_W = 16,
    parameter int OPC_W  = 4,
    parameter int DEPTH  = 16,
    parameter int RDEPTH = 16
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic [INST_W-1:0]            inst,
    input  logic                         inst_valid,
    input  logic                         mem_ready,
    input  logic [$clog2(DEPTH+1)-1:0]   stk_count,
    input  logic [$clog2(RDEPTH+1)-1:0]  rstk_count,
    output logic [2:0]                   stackOP,
    output logic [1:0]                   rStackOP,
    output logic [3:0]                   ALUOP,
    output logic [2:0]                   stackControl,
    output logic [2:0]                   PCControl,
    output logic                         MemWrite,
    output logic                         PCWrite,
    output logic                         IRWrite,
    output logic                         busy,
`ifdef STACK_TRAP_EN
    output logic                         halted,
    output logic [1:0]                   trap_cause
`else
    output logic                         halted
`endif
);

    localparam int FN_W = INST_W - OPC_W;
    localparam int SW   = $clog2(DEPTH + 1);
    localparam int RW   = $clog2(RDEPTH + 1);
    localparam logic [SW-1:0] DEPTH_C  = SW'(DEPTH);
    localparam logic [RW-1:0] RDEPTH_C = RW'(RDEPTH);

    localparam logic [2:0] SOP_NONE   = 3'd0;
    localparam logic [2:0] SOP_PUSH   = 3'd1;
    localparam logic [2:0] SOP_POPREP = 3'd2;
    localparam logic [2:0] SOP_POP    = 3'd3;
    localparam logic [2:0] SOP_POP2   = 3'd4;
    localparam logic [2:0] SOP_SWAP   = 3'd5;

    localparam logic [1:0] ROP_NONE = 2'd0;
    localparam logic [1:0] ROP_PUSH = 2'd1;
    localparam logic [1:0] ROP_POP  = 2'd3;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_A     = 4'd5;
    localparam logic [3:0] ALU_B     = 4'd6;
    localparam logic [3:0] ALU_EQ    = 4'd7;
    localparam logic [3:0] ALU_EZ    = 4'd8;
    localparam logic [3:0] ALU_BLESS = 4'd9;

    localparam logic [2:0] SC_IMM    = 3'd0;
    localparam logic [2:0] SC_IMMLUI = 3'd1;
    localparam logic [2:0] SC_MEM    = 3'd2;
    localparam logic [2:0] SC_ALU    = 3'd3;
    localparam logic [2:0] SC_INPUT  = 3'd4;

    localparam logic [2:0] PC_RETURN = 3'd0;
    localparam logic [2:0] PC_TOS    = 3'd1;
    localparam logic [2:0] PC_LABEL  = 3'd2;
    localparam logic [2:0] PC_LABINC = 3'd3;
    localparam logic [2:0] PC_PCINC  = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
`ifdef STACK_TRAP_EN
        S_HALT,
        S_TRAP
`else
        S_HALT
`endif
    } state_t;

    state_t state_q, state_d;
    logic [INST_W-1:0] ir_q, ir_d;
    logic [2:0] pendSop_q, pendSop_d;
    logic [1:0] pendRop_q, pendRop_d;
    logic       pendMw_q, pendMw_d;
    logic       pendMem_q, pendMem_d;
    logic [2:0] stackOP_q, stackOP_d;
    logic [1:0] rStackOP_q, rStackOP_d;
    logic [3:0] aluOp_q, aluOp_d;
    logic [2:0] stackCtl_q, stackCtl_d;
    logic [2:0] pcCtl_q, pcCtl_d;
    logic       memWrite_q, memWrite_d;
    logic       pcWrite_q, pcWrite_d;
    logic       irWrite_q, irWrite_d;
    logic       busy_q, busy_d;
    logic       halted_q, halted_d;
`ifdef STACK_TRAP_EN
    logic [1:0] trapCause_q, trapCause_d;
`endif

    logic [OPC_W-1:0] opc;
    logic [FN_W-1:0]  fn;
    logic [2:0] decSop;
    logic [1:0] decRop;
    logic [3:0] decAlu;
    logic [2:0] decSc;
    logic [2:0] decPc;
    logic       decMw, decMem, decHalt, decIllegal;
    logic [1:0] needStk;
    logic       needRPush, needRPop;
    logic       underflow, overflow, fault;

    assign opc = ir_q[INST_W-1 -: OPC_W];
    assign fn  = ir_q[FN_W-1:0];

    // Instruction decode plus the occupancy each instruction needs before it may commit.
    always_comb begin
        decSop     = SOP_NONE;
        decRop     = ROP_NONE;
        decAlu     = ALU_ADD;
        decSc      = SC_IMM;
        decPc      = PC_PCINC;
        decMw      = 1'b0;
        decMem     = 1'b0;
        decHalt    = 1'b0;
        decIllegal = 1'b0;
        needStk    = 2'd0;
        needRPush  = 1'b0;
        needRPop   = 1'b0;
        case (opc)
            OPC_W'(0): begin
                if (fn > FN_W'(11)) begin
                    decIllegal = 1'b1;
                end else begin
                    case (fn[3:0])
                        4'd0:  begin decSop = SOP_POPREP; decSc = SC_ALU; needStk = 2'd2; end
                        4'd1:  begin decSop = SOP_PUSH; decAlu = ALU_A; decSc = SC_ALU; needStk = 2'd1; end
                        4'd2:  begin decSop = SOP_POP; needStk = 2'd1; end
                        4'd3:  decHalt = 1'b1;
                        4'd4:  begin decSop = SOP_PUSH; decSc = SC_INPUT; end
                        4'd5:  begin decSop = SOP_POP; decPc = PC_TOS; needStk = 2'd1; end
                        4'd6:  begin decSop = SOP_PUSH; decAlu = ALU_B; decSc = SC_ALU; needStk = 2'd2; end
                        4'd7:  begin decSop = SOP_POPREP; decAlu = ALU_OR; decSc = SC_ALU; needStk = 2'd2; end
                        4'd8:  begin decRop = ROP_POP; decPc = PC_RETURN; needRPop = 1'b1; end
                        4'd9:  begin decSop = SOP_POPREP; decAlu = ALU_BLESS; decSc = SC_ALU; needStk = 2'd2; end
                        4'd10: begin decSop = SOP_POPREP; decAlu = ALU_SUB; decSc = SC_ALU; needStk = 2'd2; end
                        4'd11: begin decSop = SOP_SWAP; needStk = 2'd2; end
                        default: decIllegal = 1'b1;
                    endcase
                end
            end
            OPC_W'(1): begin decSop = SOP_POP2; decAlu = ALU_EQ; decPc = PC_LABINC; needStk = 2'd2; end
            OPC_W'(2): begin decSop = SOP_POP; decAlu = ALU_EZ; decPc = PC_LABINC; needStk = 2'd1; end
            OPC_W'(3): decPc = PC_LABEL;
            OPC_W'(4): begin decRop = ROP_PUSH; decPc = PC_LABEL; needRPush = 1'b1; end
            OPC_W'(5): begin decSop = SOP_POP; decMw = 1'b1; decMem = 1'b1; needStk = 2'd1; end
            OPC_W'(6): begin decSop = SOP_PUSH; decSc = SC_MEM; decMem = 1'b1; end
            OPC_W'(7): decSop = SOP_PUSH;
            OPC_W'(8): begin decSop = SOP_PUSH; decSc = SC_IMMLUI; end
            default:   decIllegal = 1'b1;
        endcase
    end

    assign underflow = (stk_count < SW'(needStk)) || (needRPop && (rstk_count == '0));
    assign overflow  = ((decSop == SOP_PUSH) && (stk_count >= DEPTH_C)) ||
                       (needRPush && (rstk_count >= RDEPTH_C));
    assign fault     = decIllegal || underflow || overflow;

    // Next-state and registered-output logic; strobes default low so they only pulse on commit.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pendSop_d  = pendSop_q;
        pendRop_d  = pendRop_q;
        pendMw_d   = pendMw_q;
        pendMem_d  = pendMem_q;
        stackOP_d  = SOP_NONE;
        rStackOP_d = ROP_NONE;
        memWrite_d = 1'b0;
        pcWrite_d  = 1'b0;
        irWrite_d  = 1'b0;
        aluOp_d    = aluOp_q;
        stackCtl_d = stackCtl_q;
        pcCtl_d    = pcCtl_q;
        halted_d   = halted_q;
`ifdef STACK_TRAP_EN
        trapCause_d = trapCause_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (inst_valid) begin
                    ir_d      = inst;
                    irWrite_d = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                aluOp_d    = decAlu;
                stackCtl_d = decSc;
                pcCtl_d    = decPc;
                if (decHalt) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (fault) begin
                    pcCtl_d = PC_PCINC;
`ifdef STACK_TRAP_EN
                    trapCause_d = decIllegal ? 2'd3 : (underflow ? 2'd1 : 2'd2);
                    state_d     = S_TRAP;
`else
                    // A faulted memory opcode issues no access, so it does not wait on mem_ready.
                    pendSop_d = SOP_NONE;
                    pendRop_d = ROP_NONE;
                    pendMw_d  = 1'b0;
                    pendMem_d = 1'b0;
                    state_d   = S_EXEC;
`endif
                end else begin
                    pendSop_d = decSop;
                    pendRop_d = decRop;
                    pendMw_d  = decMw;
                    pendMem_d = decMem;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!pendMem_q || mem_ready) begin
                    stackOP_d  = pendSop_q;
                    rStackOP_d = pendRop_q;
                    memWrite_d = pendMw_q;
                    pcWrite_d  = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = state_q;
        endcase
        busy_d = (state_d == S_DECODE) || (state_d == S_EXEC);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            pendSop_q  <= SOP_NONE;
            pendRop_q  <= ROP_NONE;
            pendMw_q   <= 1'b0;
            pendMem_q  <= 1'b0;
            stackOP_q  <= SOP_NONE;
            rStackOP_q <= ROP_NONE;
            aluOp_q    <= ALU_ADD;
            stackCtl_q <= SC_IMM;
            pcCtl_q    <= PC_PCINC;
            memWrite_q <= 1'b0;
            pcWrite_q  <= 1'b0;
            irWrite_q  <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
`ifdef STACK_TRAP_EN
            trapCause_q <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pendSop_q  <= pendSop_d;
            pendRop_q  <= pendRop_d;
            pendMw_q   <= pendMw_d;
            pendMem_q  <= pendMem_d;
            stackOP_q  <= stackOP_d;
            rStackOP_q <= rStackOP_d;
            aluOp_q    <= aluOp_d;
            stackCtl_q <= stackCtl_d;
            pcCtl_q    <= pcCtl_d;
            memWrite_q <= memWrite_d;
            pcWrite_q  <= pcWrite_d;
            irWrite_q  <= irWrite_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
`ifdef STACK_TRAP_EN
            trapCause_q <= trapCause_d;
`endif
        end
    end

    assign stackOP      = stackOP_q;
    assign rStackOP     = rStackOP_q;
    assign ALUOP        = aluOp_q;
    assign stackControl = stackCtl_q;
    assign PCControl    = pcCtl_q;
    assign MemWrite     = memWrite_q;
    assign PCWrite      = pcWrite_q;
    assign IRWrite      = irWrite_q;
    assign busy         = busy_q;
    assign halted       = halted_q;
`ifdef STACK_TRAP_EN
    assign trap_cause   = trapCause_q;
`endif

endmodule

// File: tb/tb_stack_control_fsm.sv
// Randomized self-checking bench for stack_control_fsm against a table-driven instruction model.
// Also builds with STACK_TRAP_EN, in which case faults are expected to trap.
module tb_stack_control_fsm;

    localparam int DEPTH  = 16;
    localparam int RDEPTH = 16;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic [4:0]  stk_count = '0;
    logic [4:0]  rstk_count = '0;
    logic [2:0]  stackOP;
    logic [1:0]  rStackOP;
    logic [3:0]  ALUOP;
    logic [2:0]  stackControl;
    logic [2:0]  PCControl;
    logic        MemWrite, PCWrite, IRWrite, busy, halted;
`ifdef STACK_TRAP_EN
    logic [1:0]  trap_cause;
`endif

    int vectorCount = 0;
    int missCount = 0;

    stack_control_fsm #(.INST_W(16), .OPC_W(4), .DEPTH(DEPTH), .RDEPTH(RDEPTH)) dut (
        .CLK(CLK), .reset(reset), .inst(inst), .inst_valid(inst_valid), .mem_ready(mem_ready),
        .stk_count(stk_count), .rstk_count(rstk_count), .stackOP(stackOP), .rStackOP(rStackOP),
        .ALUOP(ALUOP), .stackControl(stackControl), .PCControl(PCControl), .MemWrite(MemWrite),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .busy(busy),
`ifdef STACK_TRAP_EN
        .halted(halted), .trap_cause(trap_cause)
`else
        .halted(halted)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit halt; bit illegal; bit mw; bit mem; bit rPush; bit rPop;
        int sop; int rop; int alu; int sc; int pc; int minStk;
    } instrInfo_t;

    // Datapath selects per O-type function (index = function) and per opcode (index = opcode).
    int oSop[12] = '{2, 1, 3, 0, 1, 3, 1, 2, 0, 2, 2, 5};
    int oAlu[12] = '{0, 5, 0, 0, 0, 0, 6, 3, 0, 9, 1, 0};
    int oSc[12]  = '{3, 3, 0, 0, 4, 0, 3, 3, 0, 3, 3, 0};
    int oPc[12]  = '{4, 4, 4, 4, 4, 1, 4, 4, 0, 4, 4, 4};
    int pSop[9]  = '{0, 4, 3, 0, 0, 3, 1, 1, 1};
    int pAlu[9]  = '{0, 7, 8, 0, 0, 0, 0, 0, 0};
    int pSc[9]   = '{0, 0, 0, 0, 0, 0, 2, 0, 1};
    int pPc[9]   = '{4, 3, 3, 2, 2, 4, 4, 4, 4};

    function automatic instrInfo_t describe(input logic [15:0] word);
        instrInfo_t r;
        int opc, fn;
        r = '{default: 0};
        r.pc = 4;
        opc = int'(word[15:12]);
        fn = int'(word[11:0]);
        if (opc == 0) begin
            if (fn > 11) r.illegal = 1;
            else if (fn == 3) r.halt = 1;
            else begin
                r.sop = oSop[fn]; r.alu = oAlu[fn]; r.sc = oSc[fn]; r.pc = oPc[fn];
                r.rPop = (fn == 8);
                r.rop = r.rPop ? 3 : 0;
            end
        end else if (opc <= 8) begin
            r.sop = pSop[opc]; r.alu = pAlu[opc]; r.sc = pSc[opc]; r.pc = pPc[opc];
            r.mw = (opc == 5);
            r.mem = (opc == 5) || (opc == 6);
            r.rPush = (opc == 4);
            r.rop = r.rPush ? 1 : 0;
        end else begin
            r.illegal = 1;
        end
        if (r.sop == 2 || r.sop == 4 || r.sop == 5) r.minStk = 2;
        else if (r.sop == 3) r.minStk = 1;
        if (opc == 0 && fn == 1) r.minStk = 1;
        if (opc == 0 && fn == 6) r.minStk = 2;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst.stackOP", int'(stackOP), 0);
        checkOutput("rst.rStackOP", int'(rStackOP), 0);
        checkOutput("rst.ALUOP", int'(ALUOP), 0);
        checkOutput("rst.stackControl", int'(stackControl), 0);
        checkOutput("rst.PCControl", int'(PCControl), 4);
        checkOutput("rst.strobes", int'({MemWrite, PCWrite, IRWrite}), 0);
        checkOutput("rst.busy", int'(busy), 0);
        checkOutput("rst.halted", int'(halted), 0);
`ifdef STACK_TRAP_EN
        checkOutput("rst.trap_cause", int'(trap_cause), 0);
`endif
    endtask

    task automatic applyReset();
        reset = 1'b1;
        inst_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkResetState();
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH; called #1 after a clock edge with the FSM idle in FETCH.
    task automatic applyStimulus(input logic [15:0] word, input int stk, input int rstk, input int waitCycles);
        instrInfo_t e;
        bit under, over, fault;
        int cause;
        e = describe(word);
        under = (stk < e.minStk) || (e.rPop && rstk == 0);
        over = (e.sop == 1 && stk >= DEPTH) || (e.rPush && rstk >= RDEPTH);
        fault = e.illegal || under || over;
        cause = e.illegal ? 3 : (under ? 1 : 2);
        inst = word;
        inst_valid = 1'b1;
        stk_count = 5'(stk);
        rstk_count = 5'(rstk);
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge CLK); #1;
        inst_valid = 1'b0;
        inst = 16'($urandom);
        checkOutput("IRWrite", int'(IRWrite), 1);
        checkOutput("busy.decode", int'(busy), 1);
        @(posedge CLK); #1;
        checkOutput("IRWrite.pulse", int'(IRWrite), 0);
        if (e.halt) begin
            checkOutput("halted", int'(halted), 1);
            checkOutput("busy.halt", int'(busy), 0);
            checkOutput("PCWrite.halt", int'(PCWrite), 0);
            return;
        end
`ifdef STACK_TRAP_EN
        if (fault) begin
            checkOutput("trap_cause", int'(trap_cause), cause);
            checkOutput("busy.trap", int'(busy), 0);
            @(posedge CLK); #1;
            checkOutput("trap_cause.sticky", int'(trap_cause), cause);
            checkOutput("PCWrite.trap", int'(PCWrite), 0);
            applyReset();
            return;
        end
`endif
        checkOutput("ALUOP", int'(ALUOP), e.alu);
        checkOutput("stackControl", int'(stackControl), e.sc);
        checkOutput("PCControl", int'(PCControl), fault ? 4 : e.pc);
        checkOutput("PCWrite.early", int'(PCWrite), 0);
        checkOutput("busy.exec", int'(busy), 1);
        if (e.mem && !fault) begin
            mem_ready = 1'b0;
            for (int i = 0; i < waitCycles; i++) begin
                @(posedge CLK); #1;
                checkOutput("PCWrite.wait", int'(PCWrite), 0);
                checkOutput("stackOP.wait", int'(stackOP), 0);
                checkOutput("MemWrite.wait", int'(MemWrite), 0);
                checkOutput("busy.wait", int'(busy), 1);
            end
            mem_ready = 1'b1;
        end
        @(posedge CLK); #1;
        mem_ready = 1'($urandom_range(0, 1));
        checkOutput("stackOP", int'(stackOP), fault ? 0 : e.sop);
        checkOutput("rStackOP", int'(rStackOP), fault ? 0 : e.rop);
        checkOutput("MemWrite", int'(MemWrite), (e.mw && !fault) ? 1 : 0);
        checkOutput("PCWrite", int'(PCWrite), 1);
        checkOutput("PCControl.commit", int'(PCControl), fault ? 4 : e.pc);
        checkOutput("stackControl.hold", int'(stackControl), e.sc);
        checkOutput("busy.commit", int'(busy), 0);
        @(posedge CLK); #1;
        checkOutput("PCWrite.after", int'(PCWrite), 0);
        checkOutput("stackOP.after", int'(stackOP), 0);
        checkOutput("rStackOP.after", int'(rStackOP), 0);
    endtask

    initial begin
        logic [15:0] word;
        int opc;
        applyReset();

        applyStimulus(16'h0000, 3, 0, 0);
        applyStimulus(16'h6010, 4, 0, 4);
        applyStimulus(16'h5010, 4, 0, 0);
        applyStimulus(16'h0000, 1, 0, 0);
        applyStimulus(16'h4020, 2, RDEPTH, 0);
        applyStimulus(16'h0008, 2, 0, 0);
        applyStimulus(16'h7005, DEPTH, 3, 0);
        applyStimulus(16'h000B, 2, 1, 0);

        applyStimulus(16'h0003, 5, 5, 0);
        inst = 16'h0000;
        inst_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            checkOutput("halt.IRWrite", int'(IRWrite), 0);
            checkOutput("halt.halted", int'(halted), 1);
        end
        inst_valid = 1'b0;
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        checkResetState();
        applyStimulus(16'h0000, 3, 0, 0);

        for (int n = 0; n < 120; n++) begin
            opc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
            word = 16'($urandom);
            word[15:12] = 4'(opc);
            if (opc == 0)
                word[11:0] = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
            applyStimulus(word, int'($urandom_range(0, DEPTH)), int'($urandom_range(0, RDEPTH)),
                          int'($urandom_range(0, 3)));
            if (halted) applyReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/stack_control_fsm.md
Name: stack_control_fsm

Overview:
- Multi-cycle, parametrised successor to the single-cycle stack processor control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC and waits on a memory ready handshake for memory opcodes.
- Checks data-stack and return-stack occupancy before committing any stack effect.
- Drives the same datapath select encodings as the existing decoder, plus IR-write, halt and fault status.

Parameters:
- INST_W, 16, instruction width; opcode is inst[INST_W-1 -: OPC_W], O-type function is inst[INST_W-OPC_W-1:0].
- OPC_W, 4, opcode field width.
- DEPTH, 16, data stack capacity in entries.
- RDEPTH, 16, return stack capacity in entries.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inst  in  INST_W  instruction word from instruction memory.
- inst_valid  in  1  inst is valid this cycle.
- mem_ready  in  1  data memory has completed the pending access.
- stk_count  in  $clog2(DEPTH+1)  data stack occupancy.
- rstk_count  in  $clog2(RDEPTH+1)  return stack occupancy.
- stackOP  out  3  0 NONE, 1 PUSH, 2 POPANDREPLACE, 3 POP, 4 POP2, 5 SWAP.
- rStackOP  out  2  NONE/PUSH/-/POP, same codes.
- ALUOP  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 A, 6 B, 7 EQ, 8 EZ, 9 BLESSA.
- stackControl  out  3  0 IMM, 1 IMMLUI, 2 MEM, 3 ALU, 4 INPUT.
- PCControl  out  3  0 RETURN, 1 TOPOFSTACK, 2 LABEL, 3 LABELORPCINC, 4 PCINC.
- MemWrite  out  1  data memory write strobe.
- PCWrite  out  1  PC update strobe.
- IRWrite  out  1  instruction register load strobe.
- busy  out  1  high in every state except FETCH and HALT.
- halted  out  1  halt state reached.

Behaviour:
- States: FETCH, DECODE, EXEC, HALT, and TRAP (TRAP only with the optional feature). All outputs are registered.
- Reset: state FETCH. stackOP, rStackOP, ALUOP, stackControl, MemWrite, PCWrite, IRWrite, busy and halted are 0. PCControl = PCINC.
- Reset takes priority over every state, including EXEC mid-wait and HALT.
- FETCH: wait for inst_valid. On inst_valid, pulse IRWrite for 1 cycle, latch inst, go to DECODE.
- DECODE: decode the latched inst using the existing opcode map:
  - O-type functions 0-11: add, dup, drop, halt, getin, js, over, or, return, slt, sub, swap.
  - Opcodes 1-8: beq, bez, j, jal, pop(mem write), push(mem read), pushi, lui.
- DECODE loads ALUOP, stackControl and PCControl. These hold through EXEC and keep their value until the next DECODE.
- Occupancy rules, checked in DECODE:
  - POPANDREPLACE, POP2, SWAP and over need stk_count >= 2.
  - POP, dup and js need >= 1.
  - PUSH needs stk_count < DEPTH.
  - jal needs rstk_count < RDEPTH.
  - return needs rstk_count >= 1.
- A violation, or an undefined opcode/function, makes the instruction a NOP: stackOP and rStackOP NONE, PCControl = PCINC.
- EXEC: drive stackOP, rStackOP, MemWrite and PCWrite to their decoded values for exactly 1 cycle, then return to FETCH.
  - Outside that cycle, stackOP and rStackOP are NONE and the strobes are 0.
  - Opcodes 5 and 6 stay in EXEC with all strobes low until mem_ready = 1; they commit in the mem_ready cycle.
  - mem_ready is ignored in every other state.
- halt: goes from DECODE to HALT with no strobes. halted = 1 and busy = 0 until reset.
- Latency: non-memory instruction is 3 cycles from the inst_valid cycle to the PCWrite cycle. Memory instruction is 3 + wait cycles.
- beq/bez: PCControl = LABELORPCINC; the datapath resolves the branch using the ALU flag.

Optional Feature:
- Macro: STACK_TRAP_EN.
- Defined: an occupancy violation or undefined encoding in DECODE goes to TRAP instead of NOP.
  - Adds output trap_cause (2 bits): 1 underflow, 2 overflow, 3 illegal.
  - In TRAP: trap_cause is sticky, no strobes are asserted, busy = 0, and the state holds until reset.
- Undefined: trap_cause port is absent and NOP semantics apply.

Test Plan:
- reset held 2 cycles, then add (0x0000) with stk_count = 3 and inst_valid = 1 -> IRWrite in cycle 1; stackOP = 2, ALUOP = 0, stackControl = 3, PCWrite = 1 in cycle 3; back to FETCH.
- push (0x6010) with mem_ready low for 4 cycles -> stackOP = 1 and stackControl = 2 only in the mem_ready cycle; PCWrite = 0 before it.
- pop (0x5010) with mem_ready = 1 immediately -> MemWrite = 1 and stackOP = 3 for one cycle; total 3 cycles.
- add with stk_count = 1 -> without STACK_TRAP_EN: NOP, PCWrite = 1 with PCControl = 4 and stackOP = 0. With STACK_TRAP_EN: trap_cause = 1 and no PCWrite.
- jal with rstk_count = RDEPTH, then return with rstk_count = 0 -> both become NOP (or trap_cause = 2, respectively 1, when STACK_TRAP_EN is defined).
- halt (0x0003) -> halted = 1 and no further IRWrite with inst_valid held high; reset asserted in HALT -> FETCH next cycle with all outputs at reset values.
